adquisicion_temp: RTL and testbench
===================================

# adquisicion_temp

Serial acquisition front-end for the temperature monitoring path. It periodically reads a 16-bit frame from an SPI-style digital temperature sensor and extracts an 11-bit signed temperature in tenths of °C. It range-checks the value against −400..850 and presents it as a registered sample with a one-cycle valid strobe. It is the producer that feeds the temperature register stage.

## Interface
- CLK_DIV, 4: system clocks per SCLK half-period; legal range ≥4.
- SAMPLE_PERIOD, 1000: idle clocks between the end of one frame and the start of the next; legal range ≥1.
- clk  in  1  system clock, rising-edge.
- arst_n  in  1  asynchronous reset, active-low.
- en  in  1  acquisition enable, sampled only in IDLE.
- miso  in  1  sensor serial data, asynchronous to clk.
- sclk  out  1  serial clock to sensor, idle low.
- cs_n  out  1  sensor chip select, active-low.
- temp_salida  out  11 signed  last in-range temperature.
- temp_valida  out  1  one-cycle pulse when temp_salida is updated.
- error_rango  out  1  last frame was out of range.

## Operation
- Reset values: cs_n=1, sclk=0, temp_salida=220, temp_valida=0, error_rango=0, state IDLE, idle timer 0, bit counter 0.
- miso passes through a 2-FF synchronizer before any use.
- Frame format: 16 bits, MSB first. Bits[15:5] hold the temperature, two's complement. Bits[4:0] are ignored.
- States:
  - IDLE: timer counts while en=1 and holds at 0 while en=0. When timer=SAMPLE_PERIOD−1 and en=1, go to CS_SETUP with cs_n←0 and timer←0.
  - CS_SETUP: CLK_DIV cycles, sclk=0, then go to SHIFT.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles of sclk=0 followed by CLK_DIV cycles of sclk=1. The synchronized miso is shifted into a 16-bit register on the last clk cycle of each high phase. After the 16th bit, go to CS_HOLD.
  - CS_HOLD: sclk=0, cs_n←1, held for CLK_DIV cycles, then go to CHECK.
  - CHECK: single cycle, then IDLE. Let v = shift[15:5].
    - If −400 ≤ v ≤ 850: temp_salida←v, temp_valida←1 for one cycle, error_rango←0.
    - Otherwise: temp_salida is held, temp_valida stays 0, error_rango←1.
- error_rango is a level signal and is re-evaluated on every frame.
- Range comparison is signed and 11 bits wide. No saturation or clamping is applied.
- en falling mid-frame has no effect: the frame completes and the block then waits in IDLE.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The partial frame is discarded and no valid pulse is issued.

## Timing
- Frame duration, measured from the clk edge that drives cs_n low to the edge that drives cs_n high: 33·CLK_DIV cycles. This is 132 at the default.
- CHECK occurs CLK_DIV cycles after cs_n rises. temp_valida is asserted in the cycle after CHECK, and temp_salida takes its new value in that same cycle.
- Sample interval: SAMPLE_PERIOD + 34·CLK_DIV + 1 cycles. This is 1137 at the defaults.
- SCLK frequency = f_clk / (2·CLK_DIV).
- The sensor changes miso on the SCLK falling edge. Sampling the 2-cycle-delayed synchronized value at the end of the high phase requires CLK_DIV ≥ 4.
- sclk and cs_n are driven directly from registers, with no combinational path from inputs.

## Structure
- Shared package temp_pkg holds:
  - TEMP_W=11, FRAME_W=16
  - TEMP_MIN=−400, TEMP_MAX=850, TEMP_RESET=220
  - the state enum IDLE/CS_SETUP/SHIFT/CS_HOLD/CHECK
- The register stage downstream also uses TEMP_RESET from this package.
- One sub-module: sincronizador_2ff, a generic 1-bit two-flop synchronizer with clk/arst_n that resets to 0.
- The clock divider, bit counter, idle timer and FSM stay in the top module.

## Test plan
- Frame 0x1FA0 (v=253), en=1, defaults → cs_n low for 132 cycles, 16 sclk pulses, temp_salida=253, one temp_valida pulse, error_rango=0.
- Frame 0xCE00 (v=−400), followed by frame 0x6A60 (v=851) → the first frame gives temp_salida=−400 with a valid pulse. The second gives error_rango=1, no pulse, and temp_salida stays −400.
- Frame 0xCDE0 (v=−401), then 0x6A40 (v=850) → the first frame gives error_rango=1 and temp_salida=220. The second gives error_rango=0, temp_salida=850 and a valid pulse.
- en=1 continuously → successive cs_n falling edges exactly 1137 cycles apart. Then drop en during SHIFT → the current frame completes with a valid pulse, and no further cs_n activity follows.
- Assert arst_n low at bit 7 of a frame → cs_n=1, sclk=0, temp_salida=220, temp_valida=0 immediately. After release, the first frame starts SAMPLE_PERIOD cycles later.
- Frame bits[4:0] = 11111 with v=0 → temp_salida=0, proving the low bits are ignored. Repeat with CLK_DIV=6 → sclk half-period of 6 cycles and frame length of 198 cycles.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared constants and state encoding for the temperature acquisition path.
// The downstream register stage also takes its reset temperature from here.
package temp_pkg;

    localparam int TEMP_W  = 11;
    localparam int FRAME_W = 16;

    localparam logic signed [TEMP_W-1:0] TEMP_MIN   = -11'sd400;
    localparam logic signed [TEMP_W-1:0] TEMP_MAX   = 11'sd850;
    localparam logic signed [TEMP_W-1:0] TEMP_RESET = 11'sd220;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CHECK
    } estado_t;

    function automatic logic en_rango(input logic signed [TEMP_W-1:0] v);
        return (v >= TEMP_MIN) && (v <= TEMP_MAX);
    endfunction

endpackage

// File: rtl/adquisicion_temp_if.sv
// Signal bundle between the acquisition front-end, the SPI sensor and the
// temperature register stage.
interface adquisicion_temp_if;
    import temp_pkg::*;

    logic                     en;
    logic                     miso;
    logic                     sclk;
    logic                     cs_n;
    logic signed [TEMP_W-1:0] temp_salida;
    logic                     temp_valida;
    logic                     error_rango;

    modport master (
        input  en,
        input  miso,
        output sclk,
        output cs_n,
        output temp_salida,
        output temp_valida,
        output error_rango
    );

    modport slave (
        output en,
        output miso,
        input  sclk,
        input  cs_n,
        input  temp_salida,
        input  temp_valida,
        input  error_rango
    );

endinterface

// File: rtl/sincronizador_2ff.sv
// Generic 1-bit two-flop synchronizer for signals arriving from another clock domain.
module sincronizador_2ff (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adquisicion_temp.sv
// Periodic SPI read of a 16-bit temperature frame, range check and registered
// sample with a one-cycle valid strobe. CLK_DIV must be at least 4.
module adquisicion_temp
    import temp_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic               clk,
    input  logic               arst_n,
    adquisicion_temp_if.master bus
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]         BIT_LAST   = 4'd15;

    estado_t                  estado, estado_d;
    logic [TIMER_W-1:0]       timer, timer_d;
    logic [DIV_W-1:0]         div_cnt, div_d;
    logic [3:0]               bit_cnt, bit_d;
    logic                     sclk_q, sclk_d;
    logic                     cs_n_q, cs_n_d;
    logic [FRAME_W-1:0]       shift_q, shift_d;
    logic signed [TEMP_W-1:0] temp_q, temp_d;
    logic                     valida_q, valida_d;
    logic                     error_q, error_d;

    logic                     miso_s;
    logic                     div_fin;
    logic signed [TEMP_W-1:0] v;

    sincronizador_2ff u_sync_miso (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (bus.miso),
        .q      (miso_s)
    );

    assign div_fin = (div_cnt == DIV_LAST);
    assign v       = shift_q[FRAME_W-1 -: TEMP_W];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado   <= IDLE;
            timer    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            shift_q  <= '0;
            temp_q   <= TEMP_RESET;
            valida_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            estado   <= estado_d;
            timer    <= timer_d;
            div_cnt  <= div_d;
            bit_cnt  <= bit_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            shift_q  <= shift_d;
            temp_q   <= temp_d;
            valida_q <= valida_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        estado_d = estado;
        timer_d  = timer;
        div_d    = div_cnt;
        bit_d    = bit_cnt;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        shift_d  = shift_q;
        temp_d   = temp_q;
        valida_d = 1'b0;
        error_d  = error_q;

        case (estado)
            IDLE: begin
                if (!bus.en) begin
                    timer_d = '0;
                end else if (timer == TIMER_LAST) begin
                    estado_d = CS_SETUP;
                    cs_n_d   = 1'b0;
                    timer_d  = '0;
                    div_d    = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end

            CS_SETUP: begin
                if (div_fin) begin
                    estado_d = SHIFT;
                    div_d    = '0;
                    bit_d    = '0;
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end

            // Each phase lasts CLK_DIV cycles; data is captured at the end of the high phase,
            // by which time the bit launched on the previous falling edge has crossed the synchronizer.
            SHIFT: begin
                if (div_fin) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        shift_d = {shift_q[FRAME_W-2:0], miso_s};
                        if (bit_cnt == BIT_LAST) begin
                            estado_d = CS_HOLD;
                            cs_n_d   = 1'b1;
                        end else begin
                            bit_d = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end

            CS_HOLD: begin
                if (div_fin) begin
                    estado_d = CHECK;
                    div_d    = '0;
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end

            CHECK: begin
                estado_d = IDLE;
                timer_d  = '0;
                if (en_rango(v)) begin
                    temp_d   = v;
                    valida_d = 1'b1;
                    error_d  = 1'b0;
                end else begin
                    error_d = 1'b1;
                end
            end

            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    assign bus.sclk        = sclk_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.temp_salida = temp_q;
    assign bus.temp_valida = valida_q;
    assign bus.error_rango = error_q;

endmodule

// File: tb/tb_adquisicion_temp.sv
// Bench for adquisicion_temp: SPI sensor models, a frame-level reference model
// feeding a scoreboard, and timing watchers on cs_n/sclk.
module tb_adquisicion_temp;

    localparam int DIV_A   = 4;
    localparam int SP_A    = 1000;
    localparam int DIV_B   = 6;
    localparam int SP_B    = 20;
    localparam int T_RESET = 220;
    localparam int PERIODO_A = SP_A + 34 * DIV_A + 1;

    typedef struct {
        int v;
        bit ok;
    } esperado_t;

    logic clk = 1'b0;
    logic arst_n_a = 1'b0;
    logic arst_n_b = 1'b0;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    logic [15:0] frames_a[$];
    esperado_t   exp_a[$];
    int          fall_times_a[$];
    int          sclk_cnt_a = 0;
    int          done_a = 0;
    int          pulses_a = 0;
    int          exp_pulses_a = 0;

    adquisicion_temp_if bus_a ();
    adquisicion_temp_if bus_b ();

    adquisicion_temp #(.CLK_DIV(DIV_A), .SAMPLE_PERIOD(SP_A)) dut_a (
        .clk    (clk),
        .arst_n (arst_n_a),
        .bus    (bus_a)
    );

    adquisicion_temp #(.CLK_DIV(DIV_B), .SAMPLE_PERIOD(SP_B)) dut_b (
        .clk    (clk),
        .arst_n (arst_n_b),
        .bus    (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Sensor view of a frame: upper 11 bits as a two's complement number.
    function automatic int frame_to_temp(input logic [15:0] f);
        int v;
        v = int'(f) / 32;
        if (v >= 1024) v = v - 2048;
        return v;
    endfunction

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] f);
        frames_a.push_back(f);
    endtask

    function automatic logic get_sig(input bit sel_b, input bit sel_sclk);
        if (sel_b) return sel_sclk ? bus_b.sclk : bus_b.cs_n;
        return sel_sclk ? bus_a.sclk : bus_a.cs_n;
    endfunction

    task automatic wait_sig(input string name, input bit sel_b, input bit sel_sclk,
                            input logic val, input int budget, output int t);
        int n;
        n = 0;
        while (get_sig(sel_b, sel_sclk) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        checks++;
        if (get_sig(sel_b, sel_sclk) !== val) begin
            errors++;
            $display("[TB] FAIL %s: timed out after %0d cycles, got %b expected %b",
                     name, budget, get_sig(sel_b, sel_sclk), val);
        end
    endtask

    task automatic wait_done_a(input int target, input int budget);
        int n;
        n = 0;
        while (done_a < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("A frames completed", (done_a >= target), 1);
    endtask

    // Sensor A: serves queued frames, or random ones when the queue is empty, MSB first,
    // changing miso after each sclk falling edge.
    initial begin : sensor_a
        logic [15:0] f;
        int          idx;
        bit          activo;
        esperado_t   e;
        bus_a.miso = 1'b0;
        f = '0;
        idx = 0;
        activo = 1'b0;
        forever begin
            @(negedge bus_a.cs_n or posedge bus_a.cs_n or negedge bus_a.sclk);
            if (bus_a.cs_n !== 1'b0) begin
                activo = 1'b0;
            end else begin
                if (!activo) begin
                    activo = 1'b1;
                    idx = 15;
                    f = (frames_a.size() > 0) ? frames_a.pop_front() : 16'($urandom);
                    e.v  = frame_to_temp(f);
                    e.ok = (e.v >= -400) && (e.v <= 850);
                    exp_a.push_back(e);
                end else if (idx > 0) begin
                    idx--;
                end
                #1 bus_a.miso = f[idx];
            end
        end
    end

    // Sensor B always answers v=0 with the low five bits set.
    initial begin : sensor_b
        logic [15:0] f;
        int          idx;
        bit          activo;
        f = 16'h001F;
        bus_b.miso = 1'b0;
        idx = 0;
        activo = 1'b0;
        forever begin
            @(negedge bus_b.cs_n or posedge bus_b.cs_n or negedge bus_b.sclk);
            if (bus_b.cs_n !== 1'b0) begin
                activo = 1'b0;
            end else begin
                if (!activo) begin
                    activo = 1'b1;
                    idx = 15;
                end else if (idx > 0) begin
                    idx--;
                end
                #1 bus_b.miso = f[idx];
            end
        end
    end

    // Frame-shape watcher on DUT A: frame length, sclk pulse count and high-phase width.
    initial begin : watcher_a
        logic cs_prev, sclk_prev;
        int   t_fall, t_rise;
        bit   en_trama;
        cs_prev = 1'bx;
        sclk_prev = 1'bx;
        t_fall = 0;
        t_rise = 0;
        en_trama = 1'b0;
        forever begin
            @(negedge bus_a.cs_n or posedge bus_a.cs_n or posedge bus_a.sclk or negedge bus_a.sclk);
            if (arst_n_a !== 1'b1) begin
                en_trama = 1'b0;
            end else begin
                if (cs_prev === 1'b1 && bus_a.cs_n === 1'b0) begin
                    en_trama = 1'b1;
                    t_fall = cyc;
                    sclk_cnt_a = 0;
                    fall_times_a.push_back(cyc);
                end
                if (sclk_prev === 1'b0 && bus_a.sclk === 1'b1) begin
                    sclk_cnt_a++;
                    t_rise = cyc;
                end
                if (sclk_prev === 1'b1 && bus_a.sclk === 1'b0)
                    check_output("A sclk high phase", cyc - t_rise, DIV_A);
                if (cs_prev === 1'b0 && bus_a.cs_n === 1'b1 && en_trama) begin
                    en_trama = 1'b0;
                    check_output("A cs_n low length", cyc - t_fall, 33 * DIV_A);
                    check_output("A sclk pulses", sclk_cnt_a, 16);
                end
            end
            cs_prev = bus_a.cs_n;
            sclk_prev = bus_a.sclk;
        end
    end

    initial begin : pulse_counter_a
        forever begin
            @(posedge bus_a.temp_valida);
            pulses_a++;
        end
    end

    // Scoreboard monitor: resolves each completed frame against the last in-range value.
    initial begin : monitor_a
        esperado_t e;
        int        last_good;
        int        temp_esp;
        last_good = T_RESET;
        forever begin
            @(posedge bus_a.cs_n or negedge arst_n_a);
            if (arst_n_a !== 1'b1) begin
                last_good = T_RESET;
                exp_a.delete();
            end else begin
                repeat (DIV_A + 1) @(posedge clk);
                @(negedge clk);
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard: frame ended with no expected entry");
                end else begin
                    e = exp_a.pop_front();
                    if (e.ok) begin
                        last_good = e.v;
                        exp_pulses_a++;
                    end
                    temp_esp = last_good;
                    check_output("A temp_valida", bus_a.temp_valida, e.ok);
                    check_output("A temp_salida", bus_a.temp_salida, temp_esp);
                    check_output("A error_rango", bus_a.error_rango, !e.ok);
                    @(negedge clk);
                    check_output("A temp_valida width", bus_a.temp_valida, 0);
                    done_a++;
                end
            end
        end
    end

    initial begin : estimulo
        int t0, t1, t2, t3, t4, n, n_falls;

        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("A reset cs_n", bus_a.cs_n, 1);
        check_output("A reset sclk", bus_a.sclk, 0);
        check_output("A reset temp_salida", bus_a.temp_salida, T_RESET);
        check_output("A reset temp_valida", bus_a.temp_valida, 0);
        check_output("A reset error_rango", bus_a.error_rango, 0);
        check_output("B reset temp_salida", bus_b.temp_salida, T_RESET);

        // DUT B: CLK_DIV=6, low bits of the frame must not leak into the result.
        bus_b.en = 1'b1;
        arst_n_b = 1'b1;
        arst_n_a = 1'b1;
        wait_sig("B cs_n fall", 1'b1, 1'b0, 1'b0, SP_B + 10, t0);
        wait_sig("B sclk rise", 1'b1, 1'b1, 1'b1, 4 * DIV_B, t1);
        check_output("B setup plus first low phase", t1 - t0, 2 * DIV_B);
        wait_sig("B sclk fall", 1'b1, 1'b1, 1'b0, 4 * DIV_B, t2);
        check_output("B sclk high phase", t2 - t1, DIV_B);
        wait_sig("B sclk rise 2", 1'b1, 1'b1, 1'b1, 4 * DIV_B, t3);
        check_output("B sclk low phase", t3 - t2, DIV_B);
        wait_sig("B cs_n rise", 1'b1, 1'b0, 1'b1, 40 * DIV_B, t4);
        check_output("B frame length", t4 - t0, 33 * DIV_B);
        while (cyc < t4 + DIV_B + 1) @(negedge clk);
        check_output("B temp_valida", bus_b.temp_valida, 1);
        check_output("B temp_salida", bus_b.temp_salida, 0);
        check_output("B error_rango", bus_b.error_rango, 0);
        bus_b.en = 1'b0;

        // DUT A stays idle while en is low.
        repeat (1200) @(negedge clk);
        check_output("A no frame while en=0", fall_times_a.size(), 0);

        apply_stimulus(16'h1FA0);
        apply_stimulus(16'hCE00);
        apply_stimulus(16'h6A60);
        bus_a.en = 1'b1;
        wait_done_a(3, 4000);
        check_output("A interval 1", fall_times_a[1] - fall_times_a[0], PERIODO_A);
        check_output("A interval 2", fall_times_a[2] - fall_times_a[1], PERIODO_A);

        // Reset in the middle of the shift phase.
        apply_stimulus(16'h1FA0);
        wait_sig("A cs_n fall before reset", 1'b0, 1'b0, 1'b0, PERIODO_A + 50, t0);
        n = 0;
        while (sclk_cnt_a < 7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        arst_n_a = 1'b0;
        #1;
        check_output("A midframe reset cs_n", bus_a.cs_n, 1);
        check_output("A midframe reset sclk", bus_a.sclk, 0);
        check_output("A midframe reset temp_salida", bus_a.temp_salida, T_RESET);
        check_output("A midframe reset temp_valida", bus_a.temp_valida, 0);
        check_output("A midframe reset error_rango", bus_a.error_rango, 0);
        apply_stimulus(16'hCDE0);
        apply_stimulus(16'h6A40);
        apply_stimulus(16'h001F);
        repeat (3) @(negedge clk);
        arst_n_a = 1'b1;
        t1 = cyc;
        wait_sig("A cs_n fall after reset", 1'b0, 1'b0, 1'b0, SP_A + 20, t2);
        check_output("A first frame after reset", t2 - t1, SP_A);
        wait_done_a(6, 4000);

        // Random frames served by the sensor model.
        wait_done_a(11, 6500);

        // Dropping en mid-frame lets the frame finish, then the block stays idle.
        apply_stimulus(16'h0640);
        wait_sig("A cs_n fall before en drop", 1'b0, 1'b0, 1'b0, PERIODO_A + 50, t3);
        n = 0;
        while (sclk_cnt_a < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus_a.en = 1'b0;
        n_falls = fall_times_a.size();
        wait_done_a(12, 300);
        repeat (1500) @(negedge clk);
        check_output("A no frame after en drop", fall_times_a.size(), n_falls);

        check_output("A total valid pulses", pulses_a, exp_pulses_a);
        check_output("A scoreboard drained", exp_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
